// File: rtl/lsu_pkg.sv
// Shared load/store unit types: store-buffer entry layout and default sizes.
package lsu_pkg;

  localparam int unsigned SB_DEPTH  = 4;
  localparam int unsigned SB_DATA_W = 64;
  localparam int unsigned SB_ADDR_W = 64;

  // One buffered store: word address and the data to write there.
  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side store and load handshake between the MEM stage and the store buffer.
interface store_buffer_if
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = SB_ADDR_W,
  parameter int unsigned DATA_W = SB_DATA_W
);

  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  // Pipeline side issues requests.
  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr,
    input  st_ready, ld_ready, ld_data
  );

  // Store buffer side answers them.
  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr,
    output st_ready, ld_ready, ld_data
  );

endinterface

// File: rtl/sb_youngest_match.sv
// Finds the youngest occupied store-buffer slot whose address equals addr.
module sb_youngest_match
  import lsu_pkg::*;
#(
  parameter  int unsigned DEPTH = SB_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t            entries [DEPTH],
  input  logic [DEPTH-1:0]     valid,
  input  logic [PTR_W-1:0]     head,
  input  logic [PTR_W-1:0]     tail,
  input  logic [SB_ADDR_W-1:0] addr,
  output logic                 hit_c,
  output logic [PTR_W-1:0]     idx_c
);

  // Walk back from tail-1 (youngest); the first match wins, and the walk ends at head.
  always_comb begin
    logic [PTR_W-1:0] slot;
    logic             done;
    hit_c = 1'b0;
    idx_c = '0;
    slot  = '0;
    done  = 1'b0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      slot = tail - PTR_W'(k);
      if (!done && !hit_c && valid[slot] && (entries[slot].addr == addr)) begin
        hit_c = 1'b1;
        idx_c = slot;
      end
      if (slot == head) begin
        done = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer in front of a single-port DataMemory. Loads own the port;
// buffered stores retire whenever no load is using it.
// Build option STORE_FORWARD_EN: forward the youngest matching store to the load.
// Without it, a load to a buffered address stalls until that address has drained.
module store_buffer
  import lsu_pkg::*;
#(
  parameter  int unsigned DEPTH        = SB_DEPTH,
  parameter  int unsigned dataWidth    = SB_DATA_W,
  parameter  int unsigned addressWidth = SB_ADDR_W,
  localparam int unsigned PTR_W        = $clog2(DEPTH),
  localparam int unsigned CNT_W        = PTR_W + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  store_buffer_if.slave           pipe,
  output logic [addressWidth-1:0] mem_address,
  output logic [dataWidth-1:0]    mem_write_data,
  output logic                    mem_write,
  output logic                    mem_read,
  input  logic [dataWidth-1:0]    mem_read_data,
  output logic                    sb_empty,
  output logic [CNT_W-1:0]        sb_count
);

  sb_entry_t            entries_q [DEPTH];
  sb_entry_t            entries_d [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DEPTH-1:0]     valid;
  logic [SB_ADDR_W-1:0] ld_addr_w;
  logic                 match_hit;
  logic [PTR_W-1:0]     match_idx;
  logic                 ld_fire;
  logic                 drain;
  logic                 enq;

  // Occupied slots are the count_q entries starting at head_q (full when head == tail).
  always_comb begin
    logic [PTR_W-1:0] age;
    valid     = '0;
    age       = '0;
    ld_addr_w = SB_ADDR_W'(pipe.ld_addr);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      age      = PTR_W'(i) - head_q;
      valid[i] = ({1'b0, age} < count_q);
    end
  end

  sb_youngest_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .entries (entries_q),
    .valid   (valid),
    .head    (head_q),
    .tail    (tail_q),
    .addr    (ld_addr_w),
    .hit_c   (match_hit),
    .idx_c   (match_idx)
  );

  // Port arbitration, load result and FIFO next state.
  always_comb begin
    entries_d      = entries_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    pipe.st_ready  = 1'b0;
    pipe.ld_ready  = 1'b0;
    pipe.ld_data   = mem_read_data;
    mem_address    = '0;
    mem_write_data = '0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    ld_fire        = 1'b0;
    drain          = 1'b0;
    enq            = 1'b0;

    // Space is judged on registered occupancy only; a same-cycle drain does not help.
    pipe.st_ready = !reset && (count_q < CNT_W'(DEPTH));
`ifdef STORE_FORWARD_EN
    pipe.ld_ready = !reset;
    if (match_hit) begin
      pipe.ld_data = dataWidth'(entries_q[match_idx].data);
    end
`else
    pipe.ld_ready = !reset && !match_hit;
`endif

    ld_fire = pipe.ld_valid && pipe.ld_ready;
    drain   = !reset && !ld_fire && (count_q != '0);
    enq     = pipe.st_valid && pipe.st_ready;

    if (ld_fire) begin
      mem_read    = 1'b1;
      mem_address = addressWidth'(pipe.ld_addr);
    end else if (drain) begin
      mem_write      = 1'b1;
      mem_address    = addressWidth'(entries_q[head_q].addr);
      mem_write_data = dataWidth'(entries_q[head_q].data);
    end

    if (enq) begin
      entries_d[tail_q].addr = SB_ADDR_W'(pipe.st_addr);
      entries_d[tail_q].data = SB_DATA_W'(pipe.st_data);
      tail_d                 = tail_q + PTR_W'(1);
    end
    if (drain) begin
      head_d = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(enq) - CNT_W'(drain);
  end

  // FIFO pointers and occupancy; reset discards all pending stores.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; only slots covered by count_q are ever read, so no reset needed.
  always_ff @(posedge clock) begin
    entries_q <= entries_d;
  end

  // Status straight from registered occupancy.
  always_comb begin
    sb_empty = (count_q == '0);
    sb_count = count_q;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer with a word-addressed memory model.
module tb_store_buffer;
  import lsu_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 64;
  localparam int unsigned NA    = 16;
`ifdef STORE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      mem_clear;
  logic [AW-1:0]             mem_address;
  logic [DW-1:0]             mem_write_data;
  logic                      mem_write;
  logic                      mem_read;
  logic [DW-1:0]             mem_read_data;
  logic                      sb_empty;
  logic [$clog2(DEPTH):0]    sb_count;
  logic                      last_ld_ready;

  always #5 clock = ~clock;

  store_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) pipe ();

  store_buffer #(
    .DEPTH        (DEPTH),
    .dataWidth    (DW),
    .addressWidth (AW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .pipe           (pipe),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data),
    .sb_empty       (sb_empty),
    .sb_count       (sb_count)
  );

  function automatic logic [63:0] init_val(input int i);
    return (i == 3) ? 64'h5 : 64'h1000 + 64'(i);
  endfunction

  // DataMemory stand-in: combinational read, write on the rising edge.
  logic [DW-1:0] dmem [NA];
  always_comb mem_read_data = mem_read ? dmem[mem_address[3:0]] : '0;
  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < NA; i++) dmem[i] <= init_val(i);
    end else if (mem_write) begin
      dmem[mem_address[3:0]] <= mem_write_data;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: memory as retired so far, plus the queue of accepted-but-unwritten stores.
  logic [63:0] retired [NA];
  sb_entry_t   pending [$];

  function automatic logic [63:0] ref_load(input logic [63:0] a);
    logic [63:0] v;
    v = retired[a[3:0]];
    foreach (pending[i]) if (pending[i].addr == a) v = pending[i].data;
    return v;
  endfunction

  // Monitor: evaluates the settled cycle and advances the model to the next edge.
  always @(negedge clock) begin
    logic      hit;
    logic      exp_ld_ready;
    logic      exp_fire;
    logic      exp_drain;
    logic      exp_st_ready;
    sb_entry_t e;
    if (mem_clear) begin
      for (int i = 0; i < NA; i++) retired[i] = init_val(i);
    end
    if (reset) begin
      chk("rst_mem_write", 64'(mem_write), 64'd0);
      chk("rst_mem_read", 64'(mem_read), 64'd0);
      chk("rst_st_ready", 64'(pipe.st_ready), 64'd0);
      chk("rst_ld_ready", 64'(pipe.ld_ready), 64'd0);
      pending.delete();
    end else begin
      exp_st_ready = (pending.size() < DEPTH);
      chk("sb_count", 64'(sb_count), 64'(pending.size()));
      chk("sb_empty", 64'(sb_empty), 64'(pending.size() == 0));
      chk("st_ready", 64'(pipe.st_ready), 64'(exp_st_ready));
      hit = 1'b0;
      foreach (pending[i]) if (pending[i].addr == pipe.ld_addr) hit = 1'b1;
      exp_ld_ready = FWD ? 1'b1 : !hit;
      if (pipe.ld_valid) chk("ld_ready", 64'(pipe.ld_ready), 64'(exp_ld_ready));
      exp_fire  = pipe.ld_valid && exp_ld_ready;
      exp_drain = !exp_fire && (pending.size() > 0);
      chk("mem_read", 64'(mem_read), 64'(exp_fire));
      chk("mem_write", 64'(mem_write), 64'(exp_drain));
      if (exp_fire) begin
        chk("load_mem_address", mem_address, pipe.ld_addr);
        chk("ld_data", pipe.ld_data, ref_load(pipe.ld_addr));
      end else if (exp_drain) begin
        e = pending.pop_front();
        chk("drain_mem_address", mem_address, e.addr);
        chk("drain_write_data", mem_write_data, e.data);
        retired[e.addr[3:0]] = e.data;
      end else begin
        chk("idle_mem_address", mem_address, 64'd0);
      end
      if (pipe.st_valid && exp_st_ready) begin
        pending.push_back('{addr: pipe.st_addr, data: pipe.st_data});
      end
    end
  end

  // One cycle of stimulus; records ld_ready as seen mid-cycle.
  task automatic drive(input bit sv, input logic [63:0] sa, input logic [63:0] sd,
                       input bit lv, input logic [63:0] la);
    pipe.st_valid = sv;
    pipe.st_addr  = sa;
    pipe.st_data  = sd;
    pipe.ld_valid = lv;
    pipe.ld_addr  = la;
    @(negedge clock);
    last_ld_ready = pipe.ld_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 64'd0, 64'd0, 1'b0, 64'd0);
  endtask

  task automatic check_memory(input string tag);
    for (int i = 0; i < NA; i++) chk(tag, dmem[i], retired[i]);
  endtask

  initial begin
    int stalls;
    reset     = 1'b1;
    mem_clear = 1'b1;
    idle(3);
    mem_clear = 1'b0;
    reset     = 1'b0;

    // Single store drains in the following cycle.
    drive(1'b1, 64'd5, 64'hAA, 1'b0, 64'd0);
    idle(3);
    chk("t1_mem5", dmem[5], 64'hAA);

    // Fill while a load to addr 9 holds the port; extra store is refused.
    for (int i = 1; i <= 4; i++) drive(1'b1, 64'(i), 64'h100 + 64'(i), 1'b1, 64'd9);
    drive(1'b1, 64'd6, 64'hBAD, 1'b1, 64'd9);
    chk("t2_full_count", 64'(sb_count), 64'(DEPTH));
    idle(6);

    // Two stores to addr 7 then a load of addr 7.
    drive(1'b1, 64'd7, 64'h11, 1'b1, 64'd9);
    drive(1'b1, 64'd7, 64'h22, 1'b1, 64'd9);
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 64'd0, 64'd0, 1'b1, 64'd7);
      if (!last_ld_ready) stalls++;
    end
    chk("t3_stall_cycles", 64'(stalls), FWD ? 64'd0 : 64'd2);
    idle(4);
    chk("t3_mem7", dmem[7], 64'h22);

    // Same-cycle store and load to addr 3 with an empty buffer.
    drive(1'b1, 64'd3, 64'h77, 1'b1, 64'd3);
    idle(3);
    chk("t4_mem3", dmem[3], 64'h77);

    // Full buffer, then continuous stores overlapping drains across wrap.
    for (int i = 0; i < 4; i++) drive(1'b1, 64'(8 + i), {$urandom, $urandom}, 1'b1, 64'd9);
    for (int i = 0; i < 2 * DEPTH; i++) begin
      drive(1'b1, 64'($urandom_range(0, 7)), {$urandom, $urandom}, 1'b0, 64'd0);
    end
    idle(6);

    // Reset while draining with three entries left.
    for (int i = 0; i < 4; i++) drive(1'b1, 64'(10 + i), {$urandom, $urandom}, 1'b1, 64'd9);
    idle(1);
    chk("t6_count_before", 64'(sb_count), 64'd3);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    chk("t6_empty_after", 64'(sb_empty), 64'd1);
    idle(3);
    check_memory("t6_memory");

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 1)), 64'($urandom_range(0, 7)), {$urandom, $urandom},
            ($urandom_range(0, 2) == 0), 64'($urandom_range(0, 7)));
    end
    reset = 1'b0;
    idle(8);
    check_memory("final_memory");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
